// File: rtl/mem_stage.sv
// Memory-access stage: waits for data-SRAM responses, aligns and extends
// load data, and hands the result to WB over a valid/allowin handshake.
// Responses that belong to cancelled instructions are counted and dropped.
module mem_stage (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ex_to_mem_valid,
  output logic        mem_allowin,
  input  logic [31:0] ex_pc,
  input  logic [37:0] ex_rf_all,
  input  logic [3:0]  ex_ld_op,
  input  logic        ex_req_issued,
  input  logic [6:0]  ex_exc_rf,
  input  logic [31:0] ex_fault_vaddr,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  input  logic        wb_allowin,
  input  logic        cancel,
  output logic        mem_to_wb_valid,
  output logic [31:0] mem_pc,
  output logic [37:0] mem_rf_all,
  output logic [6:0]  mem_exc_rf,
  output logic [31:0] mem_fault_vaddr,
  output logic [38:0] mem_fwd,
  output logic        mem_exc_pending
);

  localparam int unsigned XLEN   = 32;
  localparam int unsigned DISC_W = 2;
  localparam int unsigned SUM_W  = 3;

  // control state
  logic              mem_valid;
  logic              req_pending;
  logic              buf_valid;
  logic [XLEN-1:0]   buf_data;
  logic [DISC_W-1:0] discard_cnt;

  // latched instruction payload
  logic [XLEN-1:0]   pc_q;
  logic              rf_we_q;
  logic [4:0]        rf_waddr_q;
  logic [XLEN-1:0]   alu_q;
  logic [3:0]        ld_op_q;
  logic [6:0]        exc_rf_q;
  logic [XLEN-1:0]   fault_q;

  logic              resp_hit;
  logic              resp_drop;
  logic              consume;
  logic              ready_go;
  logic              accept;
  logic              leave;
  logic [DISC_W-1:0] discard_nxt;
  logic [XLEN-1:0]   rf_wdata;
  logic              mem_blk;

  // A response reaches this instruction only once all stale ones are dropped
  assign resp_hit  = data_sram_data_ok & (discard_cnt == DISC_W'(0));
  assign resp_drop = data_sram_data_ok & (discard_cnt != DISC_W'(0));
  assign consume   = resp_hit & req_pending;
  assign ready_go  = ~req_pending | resp_hit;

  assign mem_to_wb_valid = mem_valid & ready_go & ~cancel;
  assign mem_allowin     = ~mem_valid | (ready_go & wb_allowin) | cancel;
  assign accept          = ex_to_mem_valid & mem_allowin & ~cancel;
  assign leave           = mem_valid & ready_go & wb_allowin;

  // Count of stale responses: grows on cancel for every in-flight request
  always_comb begin
    logic [SUM_W-1:0] sum;
    sum         = SUM_W'(0);
    discard_nxt = discard_cnt;
    if (cancel) begin
      sum = SUM_W'(discard_cnt)
          + SUM_W'(req_pending & ~resp_hit)
          + SUM_W'(ex_to_mem_valid & ex_req_issued)
          - SUM_W'(resp_drop);
      discard_nxt = (sum > SUM_W'(2)) ? DISC_W'(2) : sum[DISC_W-1:0];
    end else if (resp_drop) begin
      discard_nxt = discard_cnt - DISC_W'(1);
    end
  end

  // Load data alignment and extension; buffered data wins over live rdata
  always_comb begin
    logic [XLEN-1:0] raw;
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;
    logic            sext;
    raw      = buf_valid ? buf_data : data_sram_rdata;
    byte_sel = raw[7:0];
    half_sel = alu_q[1] ? raw[31:16] : raw[15:0];
    case (alu_q[1:0])
      2'd0:    byte_sel = raw[7:0];
      2'd1:    byte_sel = raw[15:8];
      2'd2:    byte_sel = raw[23:16];
      default: byte_sel = raw[31:24];
    endcase
    sext = ~ld_op_q[0];
    case (ld_op_q[2:1])
      2'd0:    rf_wdata = {{24{sext & byte_sel[7]}}, byte_sel};
      2'd1:    rf_wdata = {{16{sext & half_sel[15]}}, half_sel};
      default: rf_wdata = raw;
    endcase
    if (!ld_op_q[3]) rf_wdata = alu_q;
  end

  assign mem_blk         = mem_valid & ld_op_q[3] & req_pending & ~resp_hit;
  assign mem_pc          = pc_q;
  assign mem_rf_all      = {rf_we_q, rf_waddr_q, rf_wdata};
  assign mem_exc_rf      = exc_rf_q;
  assign mem_fault_vaddr = fault_q;
  assign mem_fwd         = {mem_blk, rf_we_q & mem_valid, rf_waddr_q, rf_wdata};
  assign mem_exc_pending = mem_valid & (|exc_rf_q);

  // Occupancy, pending-response and buffer-valid tracking
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_valid   <= 1'b0;
      req_pending <= 1'b0;
      buf_valid   <= 1'b0;
      discard_cnt <= DISC_W'(0);
    end else begin
      discard_cnt <= discard_nxt;
      if (cancel) begin
        mem_valid   <= 1'b0;
        req_pending <= 1'b0;
        buf_valid   <= 1'b0;
      end else if (accept) begin
        mem_valid   <= 1'b1;
        req_pending <= ex_req_issued;
        buf_valid   <= 1'b0;
      end else if (leave) begin
        mem_valid   <= 1'b0;
        req_pending <= 1'b0;
      end else if (consume) begin
        buf_valid   <= 1'b1;
        req_pending <= 1'b0;
      end
    end
  end

  // Hold a consumed response while WB is stalled
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      buf_data <= '0;
    end else if (consume && !wb_allowin && !cancel) begin
      buf_data <= data_sram_rdata;
    end
  end

  // Instruction payload capture on entry
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc_q       <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      alu_q      <= '0;
      ld_op_q    <= '0;
      exc_rf_q   <= '0;
      fault_q    <= '0;
    end else if (accept) begin
      pc_q       <= ex_pc;
      rf_we_q    <= ex_rf_all[37];
      rf_waddr_q <= ex_rf_all[36:32];
      alu_q      <= ex_rf_all[31:0];
      ld_op_q    <= ex_ld_op;
      exc_rf_q   <= ex_exc_rf;
      fault_q    <= ex_fault_vaddr;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios followed by a randomized run
// against a transaction-level model that tags every SRAM request with the
// id of the instruction that issued it.
module tb_mem_stage;

  logic        clk;
  logic        resetn;
  logic        ex_to_mem_valid;
  logic        mem_allowin;
  logic [31:0] ex_pc;
  logic [37:0] ex_rf_all;
  logic [3:0]  ex_ld_op;
  logic        ex_req_issued;
  logic [6:0]  ex_exc_rf;
  logic [31:0] ex_fault_vaddr;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        wb_allowin;
  logic        cancel;
  logic        mem_to_wb_valid;
  logic [31:0] mem_pc;
  logic [37:0] mem_rf_all;
  logic [6:0]  mem_exc_rf;
  logic [31:0] mem_fault_vaddr;
  logic [38:0] mem_fwd;
  logic        mem_exc_pending;

  mem_stage dut (
    .clk               (clk),
    .resetn            (resetn),
    .ex_to_mem_valid   (ex_to_mem_valid),
    .mem_allowin       (mem_allowin),
    .ex_pc             (ex_pc),
    .ex_rf_all         (ex_rf_all),
    .ex_ld_op          (ex_ld_op),
    .ex_req_issued     (ex_req_issued),
    .ex_exc_rf         (ex_exc_rf),
    .ex_fault_vaddr    (ex_fault_vaddr),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .wb_allowin        (wb_allowin),
    .cancel            (cancel),
    .mem_to_wb_valid   (mem_to_wb_valid),
    .mem_pc            (mem_pc),
    .mem_rf_all        (mem_rf_all),
    .mem_exc_rf        (mem_exc_rf),
    .mem_fault_vaddr   (mem_fault_vaddr),
    .mem_fwd           (mem_fwd),
    .mem_exc_pending   (mem_exc_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] alu;
    logic [3:0]  op;
    logic        iss;
    logic [6:0]  exc;
    logic [31:0] fva;
    logic [15:0] id;
  } instr_t;

  int tests = 0;
  int fails = 0;

  // model state
  instr_t      ex_i, m_i;
  logic        ex_have, m_valid, m_wait, m_hasdata;
  logic [31:0] m_data;
  logic [15:0] q_tag[$];
  logic [31:0] q_data[$];
  logic [15:0] next_id;
  logic        resp_now, eligible, hit, ready, exp_v, exp_allow;
  logic [31:0] resp_d, raw, wd;
  int          kind;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Load value from the raw word using plain shifts and two's-complement math
  function automatic logic [31:0] load_val(input logic [31:0] r, input logic [1:0] off,
                                           input logic [1:0] sz, input logic uns);
    longint v;
    int     bits;
    if (sz == 2'd0) begin
      v = longint'((r >> (int'(off) * 8)) & 32'hFF);
      bits = 8;
    end else if (sz == 2'd1) begin
      v = longint'((r >> (int'(off[1]) * 16)) & 32'hFFFF);
      bits = 16;
    end else begin
      v = longint'(r);
      bits = 32;
    end
    if (!uns && bits < 32 && v >= (64'sd1 <<< (bits - 1))) v = v - (64'sd1 <<< bits);
    return v[31:0];
  endfunction

  task automatic idle_in();
    ex_to_mem_valid   = 1'b0;
    ex_pc             = 32'd0;
    ex_rf_all         = 38'd0;
    ex_ld_op          = 4'd0;
    ex_req_issued     = 1'b0;
    ex_exc_rf         = 7'd0;
    ex_fault_vaddr    = 32'd0;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'hA5A5_A5A5;
    wb_allowin        = 1'b1;
    cancel            = 1'b0;
  endtask

  task automatic send(input logic [31:0] pc, input logic we, input logic [4:0] wa,
                      input logic [31:0] alu, input logic [3:0] op, input logic iss);
    ex_to_mem_valid = 1'b1;
    ex_pc           = pc;
    ex_rf_all       = {we, wa, alu};
    ex_ld_op        = op;
    ex_req_issued   = iss;
    ex_exc_rf       = 7'd0;
    ex_fault_vaddr  = alu;
  endtask

  task automatic resp(input logic [31:0] d);
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = d;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"},   64'(mem_to_wb_valid), 64'd0);
    chk({tag, "_allowin"}, 64'(mem_allowin),     64'd1);
    chk({tag, "_rf_all"},  64'(mem_rf_all),      64'd0);
    chk({tag, "_fwd"},     64'(mem_fwd),         64'd0);
    chk({tag, "_pc"},      64'(mem_pc),          64'd0);
    chk({tag, "_exc"},     64'(mem_exc_rf),      64'd0);
    chk({tag, "_fva"},     64'(mem_fault_vaddr), 64'd0);
    chk({tag, "_excpend"}, 64'(mem_exc_pending), 64'd0);
  endtask

  initial begin
    resetn = 1'b0;
    idle_in();
    #1;
    chk_reset_outputs("rst");

    // reset in the middle of a pending load
    @(negedge clk); resetn = 1'b1;
    @(negedge clk); send(32'h100, 1'b1, 5'd2, 32'h0000_0100, 4'b1100, 1'b1);
    @(negedge clk); idle_in(); #1;
    chk("pend_blk", 64'(mem_fwd[38]), 64'd1);
    chk("pend_valid", 64'(mem_to_wb_valid), 64'd0);
    resetn = 1'b0; #1;
    chk_reset_outputs("midrst");
    @(negedge clk); resetn = 1'b1;

    // ld.b signed: the first response after reset must be consumed directly
    @(negedge clk); send(32'h200, 1'b1, 5'd3, 32'h0000_1003, 4'b1000, 1'b1);
    @(negedge clk); idle_in(); resp(32'h8000_0000); #1;
    chk("ldb_s_valid", 64'(mem_to_wb_valid), 64'd1);
    chk("ldb_s_rf",    64'(mem_rf_all), 64'({1'b1, 5'd3, 32'hFFFF_FF80}));
    // ld.bu
    @(negedge clk); idle_in(); send(32'h204, 1'b1, 5'd3, 32'h0000_1003, 4'b1001, 1'b1);
    @(negedge clk); idle_in(); resp(32'h8000_0000); #1;
    chk("ldb_u_rf",    64'(mem_rf_all), 64'({1'b1, 5'd3, 32'h0000_0080}));
    // ld.h at offset 2
    @(negedge clk); idle_in(); send(32'h208, 1'b1, 5'd4, 32'h0000_1002, 4'b1010, 1'b1);
    @(negedge clk); idle_in(); resp(32'h8001_0000); #1;
    chk("ldh_rf",      64'(mem_rf_all), 64'({1'b1, 5'd4, 32'hFFFF_8001}));

    // data_ok three cycles after entry; an ALU op waits in EX, then follows back-to-back
    @(negedge clk); idle_in(); send(32'h40, 1'b1, 5'd7, 32'h0000_3000, 4'b1100, 1'b1);
    @(negedge clk); idle_in(); send(32'h44, 1'b1, 5'd5, 32'hDEAD_BEEF, 4'b0000, 1'b0); #1;
    chk("lat_c1_valid", 64'(mem_to_wb_valid), 64'd0);
    chk("lat_c1_allow", 64'(mem_allowin), 64'd0);
    @(negedge clk); #1;
    chk("lat_c2_valid", 64'(mem_to_wb_valid), 64'd0);
    chk("lat_c2_allow", 64'(mem_allowin), 64'd0);
    @(negedge clk); resp(32'hCAFE_F00D); #1;
    chk("lat_c3_valid", 64'(mem_to_wb_valid), 64'd1);
    chk("lat_c3_allow", 64'(mem_allowin), 64'd1);
    chk("lat_c3_rf",    64'(mem_rf_all), 64'({1'b1, 5'd7, 32'hCAFE_F00D}));
    @(negedge clk); idle_in(); #1;
    chk("alu_valid", 64'(mem_to_wb_valid), 64'd1);
    chk("alu_rf",    64'(mem_rf_all), 64'({1'b1, 5'd5, 32'hDEAD_BEEF}));
    chk("alu_fwd",   64'(mem_fwd), 64'({1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF}));
    chk("alu_pc",    64'(mem_pc), 64'h44);

    // response arrives while WB stalls: buffered and replayed with data_ok idle
    @(negedge clk); idle_in(); send(32'h80, 1'b1, 5'd9, 32'h0000_2000, 4'b1100, 1'b1);
    @(negedge clk); idle_in(); wb_allowin = 1'b0; resp(32'h1234_5678); #1;
    chk("buf_c1_valid", 64'(mem_to_wb_valid), 64'd1);
    chk("buf_c1_allow", 64'(mem_allowin), 64'd0);
    @(negedge clk); idle_in(); wb_allowin = 1'b0; #1;
    chk("buf_c2_rf",    64'(mem_rf_all), 64'({1'b1, 5'd9, 32'h1234_5678}));
    chk("buf_c2_allow", 64'(mem_allowin), 64'd0);
    @(negedge clk); idle_in(); #1;
    chk("buf_c3_valid", 64'(mem_to_wb_valid), 64'd1);
    chk("buf_c3_rf",    64'(mem_rf_all), 64'({1'b1, 5'd9, 32'h1234_5678}));
    @(negedge clk); #1;
    chk("buf_c4_valid", 64'(mem_to_wb_valid), 64'd0);

    // cancel with MEM load pending and EX request issued: two responses dropped
    @(negedge clk); idle_in(); send(32'hC0, 1'b1, 5'd1, 32'h0000_4000, 4'b1100, 1'b1);
    @(negedge clk); idle_in(); send(32'hC4, 1'b1, 5'd1, 32'h0000_4004, 4'b1100, 1'b1);
    cancel = 1'b1; #1;
    chk("can_valid", 64'(mem_to_wb_valid), 64'd0);
    chk("can_allow", 64'(mem_allowin), 64'd1);
    @(negedge clk); idle_in(); send(32'hC8, 1'b1, 5'd6, 32'h0000_4008, 4'b1100, 1'b1); #1;
    chk("can_empty", 64'(mem_to_wb_valid), 64'd0);
    @(negedge clk); idle_in(); resp(32'h1111_1111); #1;
    chk("drop1_valid", 64'(mem_to_wb_valid), 64'd0);
    chk("drop1_blk",   64'(mem_fwd[38]), 64'd1);
    @(negedge clk); idle_in(); resp(32'h2222_2222); #1;
    chk("drop2_valid", 64'(mem_to_wb_valid), 64'd0);
    @(negedge clk); idle_in(); resp(32'h3333_3333); #1;
    chk("take3_valid", 64'(mem_to_wb_valid), 64'd1);
    chk("take3_rf",    64'(mem_rf_all), 64'({1'b1, 5'd6, 32'h3333_3333}));
    @(negedge clk); idle_in();

    // randomized run against the tagged-request model
    ex_have = 1'b0; m_valid = 1'b0; m_wait = 1'b0; m_hasdata = 1'b0;
    m_data = 32'd0; m_i = '0; ex_i = '0; next_id = 16'd1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (!ex_have && $urandom_range(0, 9) < 7) begin
        kind = int'($urandom_range(0, 2));
        if (q_tag.size() >= 2) kind = 0;
        ex_i.pc  = $urandom;
        ex_i.we  = 1'($urandom);
        ex_i.wa  = 5'($urandom);
        ex_i.alu = $urandom;
        ex_i.op  = (kind == 1) ? {1'b1, 2'($urandom_range(0, 2)), 1'($urandom)} : 4'd0;
        ex_i.iss = (kind != 0);
        ex_i.exc = ($urandom_range(0, 15) == 0) ? 7'($urandom) : 7'd0;
        ex_i.fva = $urandom;
        ex_i.id  = next_id;
        next_id  = next_id + 16'd1;
        if (ex_i.iss) begin
          q_tag.push_back(ex_i.id);
          q_data.push_back($urandom);
        end
        ex_have = 1'b1;
      end
      ex_to_mem_valid = ex_have;
      ex_pc           = ex_i.pc;
      ex_rf_all       = {ex_i.we, ex_i.wa, ex_i.alu};
      ex_ld_op        = ex_i.op;
      ex_req_issued   = ex_have & ex_i.iss;
      ex_exc_rf       = ex_i.exc;
      ex_fault_vaddr  = ex_i.fva;
      // a request can only be answered once its instruction has left EX
      eligible = (q_tag.size() > 0) && !(ex_have && q_tag[0] == ex_i.id);
      resp_now = eligible && ($urandom_range(0, 1) == 1);
      resp_d   = resp_now ? q_data[0] : 32'd0;
      data_sram_data_ok = resp_now;
      data_sram_rdata   = resp_now ? resp_d : $urandom;
      wb_allowin = ($urandom_range(0, 9) < 7);
      cancel     = ($urandom_range(0, 19) == 0);
      #1;
      hit       = resp_now && m_valid && (q_tag[0] == m_i.id);
      ready     = !m_wait || hit;
      exp_v     = m_valid && ready && !cancel;
      exp_allow = !m_valid || (ready && wb_allowin) || cancel;
      chk("r_valid",   64'(mem_to_wb_valid), 64'(exp_v));
      chk("r_allowin", 64'(mem_allowin), 64'(exp_allow));
      chk("r_blk",     64'(mem_fwd[38]), 64'(m_valid && m_i.op[3] && m_wait && !hit));
      chk("r_fwd_we",  64'(mem_fwd[37]), 64'(m_valid && m_i.we));
      chk("r_excpend", 64'(mem_exc_pending), 64'(m_valid && (m_i.exc != 7'd0)));
      if (exp_v) begin
        raw = m_hasdata ? m_data : resp_d;
        wd  = m_i.op[3] ? load_val(raw, m_i.alu[1:0], m_i.op[2:1], m_i.op[0]) : m_i.alu;
        chk("r_rf_all", 64'(mem_rf_all), 64'({m_i.we, m_i.wa, wd}));
        chk("r_fwd_lo", 64'(mem_fwd[36:0]), 64'({m_i.wa, wd}));
        chk("r_pc",     64'(mem_pc), 64'(m_i.pc));
        chk("r_exc",    64'(mem_exc_rf), 64'(m_i.exc));
        chk("r_fva",    64'(mem_fault_vaddr), 64'(m_i.fva));
      end
      if (resp_now) begin
        void'(q_tag.pop_front());
        void'(q_data.pop_front());
      end
      if (cancel) begin
        m_valid = 1'b0;
        ex_have = 1'b0;
      end else if (ex_have && exp_allow) begin
        m_i       = ex_i;
        m_valid   = 1'b1;
        m_wait    = ex_i.iss;
        m_hasdata = 1'b0;
        ex_have   = 1'b0;
      end else if (m_valid && ready && wb_allowin) begin
        m_valid = 1'b0;
      end else if (hit) begin
        m_hasdata = 1'b1;
        m_data    = resp_d;
        m_wait    = 1'b0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
